serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial, LSB-first WIDTH-bit subtractor computing a - b. It is the inverse of the combinational full adder.
- One full-subtractor bit cell is reused each cycle, with a registered borrow flip-flop.
- It is a start/busy/done handshake block in the DLD arithmetic set. It trades WIDTH cycles of latency for a single bit cell.

Parameters:
- WIDTH, 8, operand and difference width in bits (WIDTH >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  WIDTH  registered difference a - b mod 2^WIDTH.
- borrow  output  1  registered final borrow-out; 1 means a < b unsigned.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, diff=0, borrow=0; internal shift regs, bit counter and borrow FF cleared.
- Reset has priority over everything. Asserting it mid-SHIFT aborts the operation, and the outputs read the reset values on the next cycle.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k: load sa<=a, sb<=b; cnt<=0; bfl<=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT:
  - Each edge: bit cell computes d = sa[0]^sb[0]^bfl and bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&bfl).
  - sd shifts right with d inserted at the MSB. sa and sb shift right. bfl<=bo. cnt<=cnt+1.
  - At the WIDTH-th shift (cnt==WIDTH-1): diff<={d, sd[WIDTH-1:1]}; borrow<=bo; go to DONE.
  - SHIFT therefore occupies edges k+1 .. k+WIDTH.
- DONE: done=1 for exactly the one cycle after edge k+WIDTH. Next edge returns to IDLE.
- start is ignored in SHIFT and DONE. The next operation can be accepted at the earliest on edge k+WIDTH+2, so back-to-back throughput is one result per WIDTH+2 cycles.
- diff and borrow hold the previous result through a new operation. They change only on the final shift edge, or on reset.
- a and b may change freely after the start edge without affecting the result.
- Counter width is $clog2(WIDTH). The counter does not wrap mid-operation because the FSM exits at WIDTH-1.
- Arithmetic: diff = (a - b) mod 2^WIDTH, borrow = (a < b) unsigned. No sign interpretation unless the optional feature is enabled.

Optional Feature:
- Macro SERIAL_SUB_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit, reset 0), registered alongside diff. ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), i.e. signed two's-complement overflow. The MSBs are captured at start.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_arith_pkg:
  - state enum ser_state_t {IDLE, SHIFT, DONE};
  - localparam function for counter width.
- Sub-module full_subtractor:
  - combinational bit cell: inputs x, y, bin; outputs d, bout.
  - instantiated once.
  - unit-tested exhaustively over 8 vectors, mirroring the full-adder bench.

Test Plan (WIDTH=8):
- start with a=0x35, b=0x12 at edge k -> busy high for edges k+1..k+8, done high one cycle after edge k+8, diff=0x23, borrow=0.
- a=0x12, b=0x35 -> diff=0xDD, borrow=1. Also a=0x00, b=0x01 -> diff=0xFF, borrow=1.
- a=0xAA, b=0xAA -> diff=0x00, borrow=0. The previous diff=0xFF stays on the outputs until the final shift edge.
- start held at 1 continuously, with a/b changed every cycle after acceptance -> only IDLE-sampled operands are used, and done pulses every 10 cycles.
- rst asserted after 4 shifts of 0x35-0x12 -> next cycle busy=0, done=0, diff=0x00, borrow=0, state IDLE. A fresh start then completes normally.
- With SERIAL_SUB_OVERFLOW_EN defined: a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1. Then a=0x05, b=0x03 -> diff=0x02, ovf=0.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state type and sizing helper for the serial subtractor
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    // Bit counter only needs to reach WIDTH-1; keep at least one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational one-bit full subtractor cell (x - y - bin)
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first a - b with start/busy/done; SERIAL_SUB_OVERFLOW_EN adds ovf
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             borrow,
    output logic             ovf
`else
    output logic             borrow
`endif
);

    localparam int CW = cnt_width(WIDTH);

    ser_state_t       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sd;
    logic [CW-1:0]    cnt;
    logic             bfl;
    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] sd_next;

    full_subtractor u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (bfl),
        .d    (cell_d),
        .bout (cell_bo)
    );

    // New difference bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
    assign sd_next = (sd >> 1) | {cell_d, {(WIDTH-1){1'b0}}};

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb;
    logic b_msb;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            cnt    <= '0;
            bfl    <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        cnt   <= '0;
                        bfl   <= 1'b0;
                        busy  <= 1'b1;
                        state <= SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sd  <= sd_next;
                    bfl <= cell_bo;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) begin
                        diff   <= sd_next;
                        borrow <= cell_bo;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        ovf    <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
